aes_key_expander: RTL

- Round-key generator that sits directly in front of the 16-byte key matrix RAM. It reads the current round key column by column and writes back the next round key in place.
- Each `next_round` request produces one AES-128 round key: RotWord/SubWord/Rcon on word 0, then XOR chaining for words 1..3.
- Driven by the cipher controller, which pulses `next_round` once per round after consuming the current key.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_sbox.sv | 33 +++
 rtl/aes_key_expander.sv | 130 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-expander FSM states, default parameters, GF(2^8) helpers.
package aes_pkg;

  localparam int         NUM_ROUNDS_DEFAULT = 10;
  localparam logic [7:0] RCON_INIT_DEFAULT  = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    ROTSUB,
    COL0,
    COL1,
    COL2,
    COL3,
    DONE
  } state_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // General GF(2^8) multiply built from repeated xtime (shift-and-add).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Computed rather than tabulated so the same block can be dropped into SubBytes.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] result
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Inverse as x^254 via an addition chain (0 maps to 0), then the affine transform.
  always_comb begin
    x2     = gf_mul(data, data);
    x3     = gf_mul(x2, data);
    x6     = gf_mul(x3, x3);
    x12    = gf_mul(x6, x6);
    x15    = gf_mul(x12, x3);
    x30    = gf_mul(x15, x15);
    x60    = gf_mul(x30, x30);
    x120   = gf_mul(x60, x60);
    x240   = gf_mul(x120, x120);
    x252   = gf_mul(x240, x12);
    inv    = gf_mul(x252, x2);
    result = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 round-key generator working in place on a 4-column key RAM.
// One next_round request rewrites the four columns with the next round key.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int         NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
  parameter logic [7:0] RCON_INIT  = RCON_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_load,
  input  logic       next_round,
  input  logic [7:0] rd_b0,
  input  logic [7:0] rd_b1,
  input  logic [7:0] rd_b2,
  input  logic [7:0] rd_b3,
  input  logic [7:0] prev_b0,
  input  logic [7:0] prev_b1,
  input  logic [7:0] prev_b2,
  input  logic [7:0] prev_b3,
  output logic [1:0] column_number,
  output logic       enable_key,
  output logic       en_key_expansion,
  output logic [7:0] wr_b0,
  output logic [7:0] wr_b1,
  output logic [7:0] wr_b2,
  output logic [7:0] wr_b3,
  output logic [3:0] round_num,
  output logic       busy,
  output logic       key_ready,
  output logic       last_round
);

  state_t      state, state_next;
  logic [7:0]  rcon;
  logic [31:0] temp;
  logic [31:0] rd_word, prev_word, wr_word;
  logic [7:0]  sb0, sb1, sb2, sb3;

  assign rd_word   = {rd_b0, rd_b1, rd_b2, rd_b3};
  assign prev_word = {prev_b0, prev_b1, prev_b2, prev_b3};
  assign {wr_b0, wr_b1, wr_b2, wr_b3} = wr_word;

  assign busy       = (state != IDLE);
  assign last_round = (round_num == 4'(NUM_ROUNDS));

  // SubWord on the old w3 presented by the RAM while enable_key is high.
  aes_sbox u_sbox0 (.data(rd_b0), .result(sb0));
  aes_sbox u_sbox1 (.data(rd_b1), .result(sb1));
  aes_sbox u_sbox2 (.data(rd_b2), .result(sb2));
  aes_sbox u_sbox3 (.data(rd_b3), .result(sb3));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Round counter, round constant and the RotWord/SubWord/Rcon temp word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_num <= 4'd0;
      rcon      <= RCON_INIT;
      temp      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            round_num <= 4'd0;
            rcon      <= RCON_INIT;
          end
        end
        ROTSUB: temp <= {sb1 ^ rcon, sb2, sb3, sb0};
        DONE: begin
          if (round_num != 4'(NUM_ROUNDS)) round_num <= round_num + 4'd1;
          rcon <= xtime(rcon);
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and the combinational RAM-side outputs.
  always_comb begin
    state_next       = state;
    column_number    = 2'd0;
    enable_key       = 1'b0;
    en_key_expansion = 1'b0;
    wr_word          = 32'h0;
    key_ready        = 1'b0;
    case (state)
      IDLE: begin
        if (!key_load && next_round && !last_round) state_next = ROTSUB;
      end
      ROTSUB: begin
        enable_key = 1'b1;
        state_next = COL0;
      end
      COL0: begin
        en_key_expansion = 1'b1;
        wr_word          = rd_word ^ temp;
        state_next       = COL1;
      end
      COL1: begin
        column_number    = 2'd1;
        en_key_expansion = 1'b1;
        wr_word          = rd_word ^ prev_word;
        state_next       = COL2;
      end
      COL2: begin
        column_number    = 2'd2;
        en_key_expansion = 1'b1;
        wr_word          = rd_word ^ prev_word;
        state_next       = COL3;
      end
      COL3: begin
        column_number    = 2'd3;
        en_key_expansion = 1'b1;
        wr_word          = rd_word ^ prev_word;
        state_next       = DONE;
      end
      DONE: begin
        key_ready  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
